// File: rtl/conway_step_ctrl.sv
// Generation scheduler for the Life cube: buttons -> run/pause/step/speed, step handshake
// with conway_sim, frame-aligned commit to cube_output. Optional macro: GEN_COUNT_EN.
module conway_step_ctrl #(
  parameter int TICK_DIV      = 100000,
  parameter int BASE_TICKS    = 16,
  parameter int DEFAULT_SPEED = 3,
  parameter int TIMEOUT_CYC   = 4096
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        BtnRun,
  input  logic        BtnStep,
  input  logic        BtnFaster,
  input  logic        BtnSlower,
  input  logic        step_done,
  input  logic        frame_sync,
  output logic        step_start,
  output logic        commit,
  output logic        running,
  output logic [2:0]  speed,
  output logic        fault,
  output logic [15:0] gen_count,
  output logic [2:0]  state_dbg
);

  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TOW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_PAUSED     = 3'd0,
    S_RUN_WAIT   = 3'd1,
    S_ISSUE      = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_WAIT_FRAME = 3'd4,
    S_COMMIT     = 3'd5
  } state_t;

  // Handshake: step_start and commit are single-cycle pulses with no ready; step_done and
  // frame_sync are single-cycle pulses that only count in the state waiting for them.
  state_t          state, state_n;
  logic [3:0]      btn_s1, btn_s2, btn_prev, btn_edge;
  logic            run_edge, step_edge, fast_edge, slow_edge;
  logic [TW-1:0]   pre_cnt;
  logic            tick;
  logic [16:0]     period_ticks, per_cnt, per_cnt_n, per_next;
  logic            per_done;
  logic [TOW-1:0]  to_cnt, to_cnt_n;
  logic            to_last;
  logic            running_n, fault_n;

  assign btn_edge  = btn_s2 & ~btn_prev;
  assign run_edge  = btn_edge[3];
  assign step_edge = btn_edge[2];
  assign fast_edge = btn_edge[1];
  assign slow_edge = btn_edge[0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_prev <= '0;
    end else begin
      btn_s1   <= {BtnRun, BtnStep, BtnFaster, BtnSlower};
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign tick = (pre_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) pre_cnt <= '0;
    else       pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
  end

  // >= rather than == so a speed-up that shrinks the period below the count fires at once.
  assign period_ticks = 17'(BASE_TICKS) << speed;
  assign per_next     = per_cnt + 17'd1;
  assign per_done     = (per_next >= period_ticks);
  assign to_last      = (to_cnt == TOW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_n   = state;
    running_n = running;
    fault_n   = fault;
    per_cnt_n = per_cnt;
    to_cnt_n  = to_cnt;
    case (state)
      S_PAUSED: begin
        if (run_edge) begin
          state_n   = S_RUN_WAIT;
          running_n = 1'b1;
          fault_n   = 1'b0;
          per_cnt_n = '0;
        end else if (step_edge) begin
          state_n = S_ISSUE;
        end
      end
      S_RUN_WAIT: begin
        if (run_edge) begin
          state_n   = S_PAUSED;
          running_n = 1'b0;
        end else if (tick) begin
          if (per_done) state_n = S_ISSUE;
          else          per_cnt_n = per_next;
        end
      end
      S_ISSUE: begin
        if (run_edge) running_n = 1'b0;
        state_n  = S_WAIT_DONE;
        to_cnt_n = '0;
      end
      S_WAIT_DONE: begin
        if (run_edge) running_n = 1'b0;
        if (step_done) begin
          state_n = S_WAIT_FRAME;
        end else if (to_last) begin
          state_n   = S_PAUSED;
          fault_n   = 1'b1;
          running_n = 1'b0;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      S_WAIT_FRAME: begin
        if (run_edge) running_n = 1'b0;
        if (frame_sync) state_n = S_COMMIT;
      end
      S_COMMIT: begin
        if (run_edge) running_n = 1'b0;
        if (running_n) begin
          state_n   = S_RUN_WAIT;
          per_cnt_n = '0;
        end else begin
          state_n = S_PAUSED;
        end
      end
      default: state_n = S_PAUSED;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= S_PAUSED;
      running <= 1'b0;
      fault   <= 1'b0;
      per_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      state   <= state_n;
      running <= running_n;
      fault   <= fault_n;
      per_cnt <= per_cnt_n;
      to_cnt  <= to_cnt_n;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      speed <= 3'(DEFAULT_SPEED);
    end else if (fast_edge && !slow_edge) begin
      if (speed != 3'd0) speed <= speed - 3'd1;
    end else if (slow_edge && !fast_edge) begin
      if (speed != 3'd7) speed <= speed + 3'd1;
    end
  end

  assign step_start = (state == S_ISSUE);
  assign commit     = (state == S_COMMIT);
  assign state_dbg  = state;

`ifdef GEN_COUNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       gen_count <= 16'h0000;
    else if (commit) gen_count <= gen_count + 16'h0001;
  end
`else
  assign gen_count = 16'h0000;
`endif

endmodule
